// File: rtl/rca_pkg.sv
// ----------------------------------------------------------------------------
// rca_pkg : shared constants, index type and FSM state encoding for rca_seq_80
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rca_pkg;

  localparam int RCA_W      = 80;
  localparam int RCA_SLICE  = 16;
  localparam int RCA_NSLICE = RCA_W / RCA_SLICE;
  localparam int RCA_IDXW   = (RCA_NSLICE > 1) ? $clog2(RCA_NSLICE) : 1;

  typedef logic [RCA_IDXW-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rca_16.sv
// ----------------------------------------------------------------------------
// rca_16 : combinational ripple-carry adder slice built from full-adder cells
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rca_16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign S[i]     = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[WIDTH];

endmodule

`default_nettype wire

// File: rtl/rca_seq_80.sv
// ----------------------------------------------------------------------------
// rca_seq_80 : 80-bit adder that reuses one 16-bit ripple slice over 5 cycles
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rca_seq_80
  import rca_pkg::*;
#(
  parameter int W     = RCA_W,
  parameter int SLICE = RCA_SLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int   NSLICE   = W / SLICE;
  localparam idx_t IDX_LAST = idx_t'(NSLICE - 1);

  state_e       state_q, state_d;
  idx_t         idx_q, idx_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] s_q, s_d;
  logic         carry_q, carry_d;
  logic         cout_q, cout_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [SLICE-1:0] w_slice_a;
  logic [SLICE-1:0] w_slice_b;
  logic [SLICE-1:0] w_slice_s;
  logic             w_slice_c;

  assign w_slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign w_slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

  rca_16 #(
    .WIDTH (SLICE)
  ) u_slice (
    .A    (w_slice_a),
    .B    (w_slice_b),
    .Cin  (carry_q),
    .S    (w_slice_s),
    .Cout (w_slice_c)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          s_d     = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        s_d[int'(idx_q)*SLICE +: SLICE] = w_slice_s;
        carry_d = w_slice_c;
        // idx stops at the last slice instead of wrapping past NSLICE-1
        if (idx_q == IDX_LAST) begin
          cout_d  = w_slice_c;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_rca_seq_80.sv
// ----------------------------------------------------------------------------
// tb_rca_seq_80 : directed scoreboard bench for the sequential 80-bit adder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rca_seq_80;

  localparam int W = 80;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_done   = 0;

  logic [W:0]   sb_q[$];
  logic [W-1:0] s_snap [0:5];

  rca_seq_80 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Scoreboard monitor: each done pulse consumes one expected {cout,s}
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got s=%h cout=%b with no expected result", s, cout);
      end else begin
        check("result", {cout, s}, sb_q.pop_front());
      end
    end
  end

  // Caller must be at a negedge with the DUT idle; returns at the negedge after E6.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W:0] exp, input bit poke);
    int lat;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    sb_q.push_back(exp);
    n_pushed++;
    @(posedge clk);
    #1 start = 1'b0; a = rnd80(); b = rnd80(); cin = 1'b1;
    @(negedge clk);
    check("busy_after_accept", {80'd0, busy}, 81'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      if (poke && (lat == 1 || lat == 4)) begin
        #1 start = 1'b1; a = rnd80(); b = rnd80(); cin = 1'b1;
      end
      if (poke && (lat == 2 || lat == 5)) begin
        #1 start = 1'b0;
      end
      @(negedge clk);
      if (lat <= 5) s_snap[lat] = s;
      check("busy_during_run", {80'd0, busy}, 81'd1);
    end
    check("done_latency", 81'(lat), 81'd5);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_done", {80'd0, busy}, 81'd0);
    check("done_one_cycle", {80'd0, done}, 81'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {80'd0, busy}, 81'd0);
    check("reset_done", {80'd0, done}, 81'd0);
    check("reset_s_cout", {cout, s}, 81'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 1 + 1
    run_add(80'd1, 80'd1, 1'b0, {1'b0, 80'd2}, 1'b0);

    // Carry through three slices
    run_add(80'h0000_0000_FFFF_FFFF_FFFF, 80'd1, 1'b0,
            {1'b0, 80'h0000_0001_0000_0000_0000}, 1'b0);
    check("inter_s_E1", {1'b0, s_snap[1]}, 81'd0);
    check("inter_s_E4", {1'b0, s_snap[4]}, {1'b0, 80'h0000_0001_0000_0000_0000});

    // Full ripple: all ones + 0 + 1
    run_add({W{1'b1}}, 80'd0, 1'b1, {1'b1, 80'd0}, 1'b0);

    // Mixed operands
    run_add(80'hABCD_EF12_3456_7890_FFFF, 80'h1111_1111_1111_1111_1111, 1'b1,
            {1'b0, 80'hBCDF_0023_4567_89A2_1111}, 1'b0);
    check("inter_s_E2", {1'b0, s_snap[2]}, {1'b0, 80'h0000_0000_0000_89A2_1111});

    // Start pulsed at E2 and E5 must be ignored
    run_add(80'd5, 80'd7, 1'b0, {1'b0, 80'd12}, 1'b1);
    check("s_after_ignored_start", {cout, s}, {1'b0, 80'd12});

    // Start held high: re-accept at E7
    a = 80'd3; b = 80'd4; cin = 1'b0; start = 1'b1;
    sb_q.push_back({1'b0, 80'd7});
    n_pushed++;
    @(posedge clk);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 5) check("hold_done_E5", {80'd0, done}, 81'd1);
      if (e == 6) begin
        check("hold_idle_E6", {80'd0, busy}, 81'd0);
        check("hold_s_E6", {1'b0, s}, {1'b0, 80'd7});
      end
      if (e == 7) begin
        check("hold_busy_E7", {80'd0, busy}, 81'd1);
        check("hold_s_cleared_E7", {1'b0, s}, 81'd0);
      end
    end
    sb_q.push_back({1'b0, 80'd7});
    n_pushed++;
    start = 1'b0;
    begin
      int lat;
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check("hold_second_latency", 81'(lat), 81'd5);
    end
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset between E3 and E4
    a = 80'd9; b = 80'd9; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {80'd0, busy}, 81'd0);
    check("async_rst_done", {80'd0, done}, 81'd0);
    check("async_rst_s_cout", {cout, s}, 81'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_add(80'd1, 80'd1, 1'b0, {1'b0, 80'd2}, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 81'(sb_q.size()), 81'd0);
    check("done_pulse_count", 81'(n_done), 81'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rca_seq_80.md
# rca_seq_80

Multi-cycle sequencer that performs an 80-bit addition by time-multiplexing a single 16-bit ripple-carry slice over five cycles. It sits beside the wide combinational adder as the area-reduced alternative. It latches operands on a start handshake, walks the slices LSB-first while carrying between them through a register, and reports the result with a one-cycle done pulse.

## Interface
Parameters:
- W, 80, total operand/result width
- SLICE, 16, width of the shared ripple-carry slice; W must be a multiple of SLICE
- NSLICE, W/SLICE (5), derived slice count; not overridable

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  W  operand A, sampled on accepted start
- b  input  W  operand B, sampled on accepted start
- cin  input  1  carry-in, sampled on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: s/cout final
- s  output  W  sum register
- cout  output  1  carry-out of slice NSLICE-1

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 at an edge → latch a, b, cin into operand regs and carry reg. Clear s to 0 and idx to 0. Go to RUN.
- RUN, each edge:
  - s[idx*SLICE +: SLICE] ← slice sum of a_r/b_r slice idx plus carry reg.
  - carry reg ← slice carry-out.
  - idx ← idx+1.
- On the edge that writes slice NSLICE-1: cout ← slice carry-out, go to DONE.
- DONE: one cycle, done=1. Next edge goes to IDLE.
- s and cout hold their values in IDLE until the next accepted start.
- `start` in RUN or DONE is ignored. It is not queued. The a/b/cin inputs may change freely after acceptance.
- Arithmetic: unsigned modulo 2^W. {cout,s} = a + b + cin exactly.
- idx is 3 bits and counts 0..NSLICE-1. It never wraps in RUN, because the state exits at NSLICE-1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0, idx=0, carry reg=0, operand regs=0.
- Start accepted at edge E0:
  - busy=1 after E0.
  - Slice k is written at edge E(k+1), for k=0..4.
  - done=1 and final cout are visible after E5. Latency from accepting edge to done is NSLICE = 5 cycles.
  - done and busy both drop after E6.
- Earliest next accept is E7: state is IDLE after E6, so start is sampled at E7. The throughput limit is one addition per 7 edges (NSLICE+2).
- start held high continuously re-triggers on every return to IDLE.
- Reset asserted mid-RUN or in DONE:
  - Immediate, without waiting for a clock edge, return to all reset values. The in-flight operation is lost and no done pulse is issued.
  - First start is accepted on the first edge after rst deasserts.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Package rca_pkg:
  - Constants W, SLICE, NSLICE.
  - State enum {IDLE, RUN, DONE}.
  - Index type sized $clog2(NSLICE).
- Sub-module rca_16: combinational 16-bit ripple-carry adder. Ports A, B, Cin, S, Cout, built from full-adder cells. Instantiated once and driven by the idx-selected operand slices.
- Top holds the FSM, idx counter, operand regs, carry reg and s/cout regs.

## Test plan
- Basic: a=1, b=1, cin=0.
  - Expect done exactly 5 cycles after the accepting edge.
  - Expect s=0x0000_0000_0000_0000_0002, cout=0.
  - busy high from E0 through E5.
- Multi-slice carry: a=0x0000_0000_FFFF_FFFF_FFFF, b=1, cin=0.
  - Expect s=0x0000_0001_0000_0000_0000, cout=0.
  - Check intermediate s after E1 = 0x…0000 in slice 0.
- Full ripple: a=all-ones, b=0, cin=1.
  - Expect s=0, cout=1.
- Mixed: a=0xABCD_EF12_3456_7890_FFFF, b=0x1111_1111_1111_1111_1111, cin=1.
  - Expect s=0xBCDF_0023_4567_89A2_1111, cout=0.
- Start while busy:
  - Pulse start with new operands at E2 and E5. Expect them ignored and the original result unchanged.
  - Hold start high continuously. Expect the next accept at E7, with s cleared to 0 after E7.
- Reset mid-run: assert rst between E3 and E4.
  - Expect busy=0, done=0, s=0, cout=0 immediately. No done pulse.
  - A new add (1+1) after deassert completes normally with s=2.
